// File: rtl/adder_n_bit_reg_if.sv
// Operand/result bundle for the registered N-bit adder.
// The master drives the operands; the slave returns the sum and flags.
interface adder_n_bit_reg_if #(
  parameter int N = 4
);
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] out;
  logic         cout;
  logic         overflow;

  modport master (
    output in_a,
    output in_b,
    input  out,
    input  cout,
    input  overflow
  );

  modport slave (
    input  in_a,
    input  in_b,
    output out,
    output cout,
    output overflow
  );
endinterface

// File: rtl/adder_n_bit_reg.sv
// N-bit ripple-carry adder with registered sum, carry-out and signed overflow.
// Results appear one clock after the operands are sampled.
module adder_n_bit_reg #(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adder_n_bit_reg_if.slave       bus
);
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [N:0]   carry;
  logic [N-1:0] sum_next;
  logic         cout_next;
  logic         overflow_next;

  logic [N-1:0] out_reg;
  logic         cout_reg;
  logic         overflow_reg;

  assign a_in     = bus.in_a;
  assign b_in     = bus.in_b;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      assign sum_next[gi]  = a_in[gi] ^ b_in[gi] ^ carry[gi];
      assign carry[gi + 1] = (a_in[gi] & b_in[gi]) | (carry[gi] & (a_in[gi] ^ b_in[gi]));
    end
  endgenerate

  // Signed overflow: carries into and out of the sign bit disagree.
  assign cout_next     = carry[N];
  assign overflow_next = carry[N] ^ carry[N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      out_reg      <= sum_next;
      cout_reg     <= cout_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.out      = out_reg;
  assign bus.cout     = cout_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_adder_n_bit_reg.sv
// Scoreboard bench for adder_n_bit_reg at N=4: directed cases, async reset
// behaviour and an exhaustive sweep of all operand pairs.
module tb_adder_n_bit_reg;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] o;
    logic         c;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  adder_n_bit_reg_if #(.N(N)) bus ();

  adder_n_bit_reg #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add, overflow from the operand/sum sign rule.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic [N:0] s;
    s   = {1'b0, a} + {1'b0, b};
    e.a = a;
    e.b = b;
    e.o = s[N-1:0];
    e.c = s[N];
    e.v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, ".out"},      32'(bus.out),      32'd0);
    check_eq({tag, ".cout"},     32'(bus.cout),     32'd0);
    check_eq({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
    $display("zero-check %s out=%b cout=%b ovf=%b", tag, bus.out, bus.cout, bus.overflow);
  endtask

  task automatic pop_compare();
    exp_t e;
    string tag;
    if (exp_q.size() == 0) return;
    e   = exp_q.pop_front();
    tag = $sformatf("%0d+%0d", e.a, e.b);
    check_eq({tag, ".out"},      32'(bus.out),      32'(e.o));
    check_eq({tag, ".cout"},     32'(bus.cout),     32'(e.c));
    check_eq({tag, ".overflow"}, 32'(bus.overflow), 32'(e.v));
    $display("txn %s -> out=%b cout=%b ovf=%b (exp %b %b %b)",
             tag, bus.out, bus.cout, bus.overflow, e.o, e.c, e.v);
  endtask

  // One cycle: compare the result launched last cycle, then drive new operands.
  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    pop_compare();
    bus.in_a = a;
    bus.in_b = b;
    exp_q.push_back(model(a, b));
  endtask

  task automatic flush();
    @(negedge clk);
    pop_compare();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.in_a = 4'd5;
    bus.in_b = 4'd3;

    // Held in reset across several edges.
    #1;
    check_zero("reset_t0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero($sformatf("reset_hold%0d", i));
    end
    rst_n = 1'b1;
    exp_q.push_back(model(4'd5, 4'd3));

    // Directed cases, back-to-back.
    step(4'd0,  4'd0);
    step(4'd1,  4'd0);
    step(4'd1,  4'd1);
    step(4'd3,  4'd4);
    step(4'd15, 4'd15);
    step(4'd6,  4'd2);
    step(4'd7,  4'd1);
    step(4'd8,  4'd8);
    step(4'd15, 4'd15);
    step(4'd3,  4'd3);

    // 15+15 result (1110) is on the outputs; reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    @(negedge clk);
    check_zero("async_rst_hold");
    rst_n = 1'b1;
    exp_q.push_back(model(4'd3, 4'd3));

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step(4'(a), 4'(b));
      end
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_n_bit_reg.md
Name:
adder_n_bit_reg

Overview:
- Parameterised N-bit two's-complement / unsigned binary adder with registered outputs.
- Computes in_a + in_b with no carry-in. Reports the N-bit sum, the unsigned carry-out and the signed overflow flag.
- Serves as the add datapath element of the ALU. Results are presented one clock after the operands are sampled.

Parameters:
- N, 4, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset; clears all output registers.
- in_a  input  N  operand A (unsigned or two's complement, same bit pattern).
- in_b  input  N  operand B.
- out  output  N  registered sum bits [N-1:0] of in_a + in_b.
- cout  output  1  registered carry out of bit N-1 (unsigned overflow).
- overflow  output  1  registered signed overflow flag.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low forces out=0, cout=0, overflow=0 immediately, independent of clk.
  - Outputs hold these values while rst_n is low.
  - The first capture happens on the first rising clk edge after rst_n deasserts.
- Datapath:
  - Ripple-carry chain of N full-adder cells built with a generate loop.
  - Carry into bit 0 is 0.
  - For cell i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
- Flags:
  - Carry-out: cout_next = c[N].
  - Signed overflow: overflow_next = c[N] ^ c[N-1]. This is equivalent to both operands having the same sign and the sum sign differing from it.
- Register stage:
  - On every rising clk edge with rst_n high: out<=s, cout<=cout_next, overflow<=overflow_next.
  - Latency is exactly 1 cycle. Throughput is 1 result per cycle; there is no stall or enable.
- Widths:
  - Sum wraps modulo 2^N. The (N+1)-bit value {cout,out} equals in_a+in_b exactly as an unsigned sum.
- Boundaries:
  - Max + max (all ones + all ones) -> out = all ones except LSB 0, cout=1, overflow=0.
  - Most-negative + most-negative -> out=0, cout=1, overflow=1.
  - Most-positive + 1 -> out=most-negative, cout=0, overflow=1.
- Input timing:
  - Inputs changing between edges have no effect until the next edge; no glitches reach the outputs.
- Reset mid-operation:
  - Asserting rst_n discards the in-flight result, and outputs go to 0 asynchronously.
  - After release, the next edge captures the current inputs.

Test Plan:
- Reset: hold rst_n=0 with in_a=5, in_b=3 and toggle clk -> out=0000, cout=0, overflow=0 throughout. Release rst_n -> after the next edge out=1000, cout=0, overflow=0.
- Basic sums (N=4), each checked one cycle after applying inputs:
  - 0+0 -> out=0000, cout=0, overflow=0.
  - 1+0 -> out=0001, cout=0, overflow=0.
  - 1+1 -> out=0010, cout=0, overflow=0.
  - 3+4 -> out=0111, cout=0, overflow=0.
- Carry without overflow: 15+15 -> out=1110, cout=1, overflow=0 (-1 + -1 = -2).
- Overflow without carry: 6+2 -> out=1000, cout=0, overflow=1. Also 7+1 -> out=1000, cout=0, overflow=1.
- Carry and overflow: 8+8 -> out=0000, cout=1, overflow=1. Back-to-back inputs changing every cycle produce matching results with exactly 1-cycle latency.
- Async reset mid-stream: assert rst_n between edges while out=1110 -> outputs clear to 0 before the next edge. Also run an exhaustive 4-bit sweep of all 256 (in_a, in_b) pairs, checking {cout,out}=in_a+in_b and overflow against the sign rule.
